// File: rtl/uart_tx_serializer_if.sv
// Byte-in / serial-out link between a host byte source and the UART transmitter.
//   start : host request to send din (host -> tx)
//   din   : byte to send, captured on accept (host -> tx)
//   tx    : serial line, idles high (tx -> pin)
//   busy  : frame in progress (tx -> host)
//   done  : one-clk pulse at end of stop bit (tx -> host)
interface uart_tx_serializer_if;
    logic       start;
    logic [7:0] din;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (output start, output din, input tx, input busy, input done);
    modport slave  (input start, input din, output tx, output busy, output done);
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with 16x oversample tick timing (receiver counterpart).
// Optional even-parity bit between data bit 7 and stop bit when UART_TX_PARITY_EN
// is defined (8E1, 11-bit frame); otherwise 10-bit 8N1 frames.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of uart_tx_serializer_if (start/din in; tx/busy/done out)
// Parameters:
//   CLKS_PER_TICK : clk cycles per oversample tick (>= 1)
//   TICKS_PER_BIT : oversample ticks per serial bit (16)
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_TICK = 27,
    parameter int unsigned TICKS_PER_BIT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_tx_serializer_if.slave    bus
);

    localparam int unsigned DIV_W  = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int unsigned TCNT_W = 4;
    localparam int unsigned BIDX_W = 3;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP_BIT
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [BIDX_W-1:0]   bidx_q, bidx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tick_c;
    logic                bit_end_c;
`ifdef UART_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    // Tick on divider terminal count; a bit ends on the 16th tick.
    assign tick_c    = (div_q == DIV_W'(CLKS_PER_TICK - 1));
    assign bit_end_c = tick_c && (tcnt_q == TCNT_W'(TICKS_PER_BIT - 1));

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            tcnt_q   <= '0;
            bidx_q   <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            tcnt_q   <= tcnt_d;
            bidx_q   <= bidx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state, counters and next registered outputs.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        tcnt_d   = tcnt_q;
        bidx_d   = bidx_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        if (state_q != IDLE) begin
            div_d = tick_c ? '0 : div_q + DIV_W'(1);
            if (tick_c) begin
                tcnt_d = bit_end_c ? '0 : tcnt_q + TCNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d  = bus.din;
                    div_d    = '0;
                    tcnt_d   = '0;
                    bidx_d   = '0;
                    state_d  = START_BIT;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.din;
`endif
                end
            end
            START_BIT: begin
                if (bit_end_c) state_d = DATA;
            end
            DATA: begin
                if (bit_end_c) begin
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    bidx_d  = bidx_q + BIDX_W'(1);
                    if (bidx_q == BIDX_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP_BIT;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_c) state_d = STOP_BIT;
            end
`endif
            STOP_BIT: begin
                if (bit_end_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs follow the state being entered so tx/busy change on the accept edge.
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP_BIT) && bit_end_c;
        case (state_d)
            START_BIT: tx_d = 1'b0;
            DATA:      tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:    tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
